jreq_encoder: RTL and testbench

JREQ_ENCODER -- requirements
Module: jreq_encoder

---
 rtl/jreq_encoder.sv | 105 ++++++++++
 tb/tb_jreq_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jreq_encoder.sv
// Request-to-index encoder: latches request lines into a pending register and
// offers one pending index per handshake. Define JREQ_ENCODER_RR_EN for round-robin selection.
module jreq_encoder #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [N-1:0] bis,
  input  logic         wack,
  output logic [M-1:0] bos,
  output logic         wvalid,
  output logic [N-1:0] wpend,
  output logic         wovf
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]   r_state;
  logic [N-1:0] r_pend;
  logic [M-1:0] r_bos;
  logic         r_ovf;

  logic         w_load;
  logic         w_any;
  logic         w_do_load;
  logic [M-1:0] w_sel;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic         w_ovf_hit;

  function automatic logic [M-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = M'(i);
    end
  endfunction

  assign w_any     = |r_pend;
  assign w_load    = (r_state == ST_IDLE) || wack;
  assign w_do_load = w_load && w_any;

`ifdef JREQ_ENCODER_RR_EN
  logic [M-1:0] r_ptr;
  logic [N-1:0] w_hi_mask;
  logic [N-1:0] w_masked;

  // Candidates strictly above the last loaded index are tried first, then wrap.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign w_hi_mask[gi] = (M'(gi) > r_ptr);
    end
  endgenerate

  assign w_masked = r_pend & w_hi_mask;
  assign w_sel    = (|w_masked) ? lowest_set(w_masked) : lowest_set(r_pend);

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_ptr <= M'(N - 1);
    end else if (w_do_load) begin
      r_ptr <= w_sel;
    end
  end
`else
  assign w_sel = lowest_set(r_pend);
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign w_clr[gi] = w_do_load && (w_sel == M'(gi));
    end
  endgenerate

  // A fresh request on a bit being cleared this edge keeps the bit set.
  assign w_pend_next = (r_pend & ~w_clr) | bis;
  assign w_ovf_hit   = |(bis & r_pend & ~w_clr);

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_bos   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_load) begin
        if (w_any) begin
          r_bos   <= w_sel;
          r_state <= ST_OFFER;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign bos    = r_bos;
  assign wvalid = (r_state == ST_OFFER);
  assign wpend  = r_pend;
  assign wovf   = r_ovf;

endmodule

// File: tb/tb_jreq_encoder.sv
// Directed bench for jreq_encoder: latency, backpressure, overflow, reset and
// selection order; expectations are hand-computed per step.
module tb_jreq_encoder;

  logic       wclk;
  logic       wrst_n;
  logic [7:0] bis;
  logic       wack;
  logic [2:0] bos;
  logic       wvalid;
  logic [7:0] wpend;
  logic       wovf;

  int n_checks;
  int n_fails;

  jreq_encoder #(.N(8), .M(3)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bis    (bis),
    .wack   (wack),
    .bos    (bos),
    .wvalid (wvalid),
    .wpend  (wpend),
    .wovf   (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    bis    = 8'h00;
    wack   = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    wrst_n = 1'b0;
    bis    = 8'h00;
    wack   = 1'b0;
    tick();
    tick();
    check("rst_bos",    32'(bos),    32'h0);
    check("rst_wvalid", 32'(wvalid), 32'h0);
    check("rst_wpend",  32'(wpend),  32'h00);
    check("rst_wovf",   32'(wovf),   32'h0);
    wrst_n = 1'b1;

    // Two requests drained back-to-back with wack held high.
    bis = 8'h24; wack = 1'b1;
    tick();
    check("lat_e0_wpend",  32'(wpend),  32'h24);
    check("lat_e0_wvalid", 32'(wvalid), 32'h0);
    bis = 8'h00;
    tick();
    check("e1_bos",    32'(bos),    32'h2);
    check("e1_wvalid", 32'(wvalid), 32'h1);
    check("e1_wpend",  32'(wpend),  32'h20);
    tick();
    check("e2_bos",    32'(bos),    32'h5);
    check("e2_wvalid", 32'(wvalid), 32'h1);
    tick();
    check("e3_wvalid", 32'(wvalid), 32'h0);
    check("e3_wpend",  32'(wpend),  32'h00);
    check("e3_bos",    32'(bos),    32'h5);
    $display("txn: drain 8'h24 with wack=1 done");

    // Backpressure: offer must hold steady while wack is low.
    do_reset();
    bis = 8'h24; wack = 1'b0;
    tick();
    bis = 8'h00;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_bos",    32'(bos),    32'h2);
      check("bp_wvalid", 32'(wvalid), 32'h1);
      check("bp_wpend",  32'(wpend),  32'h20);
    end
    wack = 1'b1;
    tick();
    wack = 1'b0;
    check("bp_next_bos",    32'(bos),    32'h5);
    check("bp_next_wvalid", 32'(wvalid), 32'h1);
    check("bp_next_wpend",  32'(wpend),  32'h00);
    $display("txn: backpressure hold and release done");

    // Re-request of the offered index, then overflow on index 5.
    do_reset();
    bis = 8'h04; wack = 1'b0;
    tick();
    bis = 8'h00;
    tick();
    check("ov_offer_bos", 32'(bos), 32'h2);
    bis = 8'h04;
    tick();
    check("rereq_wpend", 32'(wpend), 32'h04);
    check("rereq_wovf",  32'(wovf),  32'h0);
    bis = 8'h20;
    tick();
    check("ov_first_wpend", 32'(wpend), 32'h24);
    check("ov_first_wovf",  32'(wovf),  32'h0);
    tick();
    check("ov_second_wovf", 32'(wovf), 32'h1);
    bis = 8'h00;
    for (int i = 0; i < 20; i++) tick();
    check("ov_sticky_wovf",   32'(wovf),   32'h1);
    check("ov_sticky_bos",    32'(bos),    32'h2);
    check("ov_sticky_wvalid", 32'(wvalid), 32'h1);
    $display("txn: overflow sticky done");

    // Reset mid-offer with pending requests; inputs active during reset are ignored.
    wrst_n = 1'b0; bis = 8'hFF; wack = 1'b1;
    tick();
    check("mid_rst_wvalid", 32'(wvalid), 32'h0);
    check("mid_rst_bos",    32'(bos),    32'h0);
    check("mid_rst_wpend",  32'(wpend),  32'h00);
    check("mid_rst_wovf",   32'(wovf),   32'h0);
    wrst_n = 1'b1; bis = 8'h00; wack = 1'b0;
    tick();
    tick();
    check("post_rst_wvalid", 32'(wvalid), 32'h0);
    check("post_rst_wpend",  32'(wpend),  32'h00);
    $display("txn: reset mid-offer done");

    // Same-bit clear and request: request wins without overflow.
    do_reset();
    bis = 8'h01; wack = 1'b1;
    tick();
    tick();
    check("same_e1_bos",   32'(bos),   32'h0);
    check("same_e1_wpend", 32'(wpend), 32'h01);
    check("same_e1_wovf",  32'(wovf),  32'h0);
    tick();
    check("same_e2_bos",    32'(bos),    32'h0);
    check("same_e2_wvalid", 32'(wvalid), 32'h1);
    check("same_e2_wovf",   32'(wovf),   32'h0);
    $display("txn: simultaneous clear/request done");

    // bis=8'h03 held: order depends on selection policy.
    do_reset();
    bis = 8'h03; wack = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef JREQ_ENCODER_RR_EN
      check("hold03_rr_bos", 32'(bos), 32'(i % 2));
`else
      check("hold03_fp_bos",   32'(bos),      32'h0);
      check("hold03_fp_pend1", 32'(wpend[1]), 32'h1);
`endif
      check("hold03_wvalid", 32'(wvalid), 32'h1);
    end
    check("hold03_wovf", 32'(wovf), 32'h1);
    $display("txn: held 8'h03 sequence done");

    // All lines once: indices 0..7 on consecutive edges, then idle.
    do_reset();
    bis = 8'hFF; wack = 1'b1;
    tick();
    bis = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("all_bos",    32'(bos),    32'(i));
      check("all_wvalid", 32'(wvalid), 32'h1);
    end
    tick();
    check("all_end_wvalid", 32'(wvalid), 32'h0);
    check("all_end_wpend",  32'(wpend),  32'h00);
    $display("txn: sweep 8'hFF done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
